// File: rtl/div_sequencer.sv
// Sequencer between issue and the iterative unsigned divider: RV64M sign fix-up, zero/overflow bypass, flush.
// Optional DIV_WORD_OP_EN adds req_word and the 32-bit W-suffixed ops.
module div_sequencer #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
`ifdef DIV_WORD_OP_EN
  input  logic             req_word,
`endif
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             core_start,
  output logic             core_abort,
  output logic [XLEN-1:0]  core_dividend,
  output logic [XLEN-1:0]  core_divisor,
  input  logic             core_done,
  input  logic [XLEN-1:0]  core_quotient,
  input  logic [XLEN-1:0]  core_remainder,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag
);

  typedef enum logic [1:0] {IDLE, START, CALC, RESP} state_e;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x, input logic w);
    return w ? {{(XLEN-32){x[31]}}, x[31:0]} : x;
  endfunction

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              core_start_q, core_start_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_data_q, resp_data_d;
  logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;
  logic [XLEN-1:0]   core_dividend_q, core_dividend_d;
  logic [XLEN-1:0]   core_divisor_q, core_divisor_d;
  logic [1:0]        op_q, op_d;
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic              word_q, word_d;

  logic              word_en, is_signed, neg_a, neg_b, div_zero, ovf;
  logic [XLEN-1:0]   a_ext, b_ext, byp_data, q_fix, r_fix;

`ifdef DIV_WORD_OP_EN
  assign word_en = req_word;
`else
  assign word_en = 1'b0;
`endif

  // Operand preparation for the request currently presented.
  always_comb begin
    is_signed = ~req_op[0];
    a_ext     = req_rs1;
    b_ext     = req_rs2;
    div_zero  = (req_rs2 == '0);
    ovf       = is_signed && (req_rs1 == MIN_NEG) && (req_rs2 == '1);
    if (word_en) begin
      a_ext    = is_signed ? sext_w(req_rs1, 1'b1) : {{(XLEN-32){1'b0}}, req_rs1[31:0]};
      b_ext    = is_signed ? sext_w(req_rs2, 1'b1) : {{(XLEN-32){1'b0}}, req_rs2[31:0]};
      div_zero = (req_rs2[31:0] == 32'h0);
      ovf      = is_signed && (req_rs1[31:0] == 32'h8000_0000) && (req_rs2[31:0] == 32'hFFFF_FFFF);
    end
    neg_a    = is_signed & a_ext[XLEN-1];
    neg_b    = is_signed & b_ext[XLEN-1];
    // Div-by-zero: q = all-ones, r = dividend. Overflow: q = dividend, r = 0.
    if (req_op[1]) byp_data = div_zero ? a_ext : '0;
    else           byp_data = div_zero ? '1 : a_ext;
    q_fix    = (neg_a_q ^ neg_b_q) ? -core_quotient : core_quotient;
    r_fix    = neg_a_q ? -core_remainder : core_remainder;
  end

  always_comb begin
    state_d         = state_q;
    core_start_d    = 1'b0;
    resp_valid_d    = resp_valid_q;
    resp_data_d     = resp_data_q;
    resp_tag_d      = resp_tag_q;
    core_dividend_d = core_dividend_q;
    core_divisor_d  = core_divisor_q;
    op_d            = op_q;
    neg_a_d         = neg_a_q;
    neg_b_d         = neg_b_q;
    word_d          = word_q;
    case (state_q)
      IDLE: if (req_valid) begin
        op_d            = req_op;
        word_d          = word_en;
        neg_a_d         = neg_a;
        neg_b_d         = neg_b;
        resp_tag_d      = req_tag;
        core_dividend_d = neg_a ? -a_ext : a_ext;
        core_divisor_d  = neg_b ? -b_ext : b_ext;
        if (div_zero || ovf) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = sext_w(byp_data, word_en);
        end else begin
          state_d      = START;
          core_start_d = 1'b1;
        end
      end
      START: state_d = CALC;
      CALC: if (core_done) begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_data_d  = sext_w(op_q[1] ? r_fix : q_fix, word_q);
      end
      RESP: if (resp_ready) begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over everything, including acceptance in IDLE.
    if (flush) begin
      state_d         = IDLE;
      core_start_d    = 1'b0;
      resp_valid_d    = 1'b0;
      resp_data_d     = resp_data_q;
      resp_tag_d      = resp_tag_q;
      core_dividend_d = core_dividend_q;
      core_divisor_d  = core_divisor_q;
      op_d            = op_q;
      neg_a_d         = neg_a_q;
      neg_b_d         = neg_b_q;
      word_d          = word_q;
    end
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      req_ready_q     <= 1'b1;
      core_start_q    <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= '0;
      resp_tag_q      <= '0;
      core_dividend_q <= '0;
      core_divisor_q  <= '0;
      op_q            <= 2'b00;
      neg_a_q         <= 1'b0;
      neg_b_q         <= 1'b0;
      word_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      req_ready_q     <= req_ready_d;
      core_start_q    <= core_start_d;
      resp_valid_q    <= resp_valid_d;
      resp_data_q     <= resp_data_d;
      resp_tag_q      <= resp_tag_d;
      core_dividend_q <= core_dividend_d;
      core_divisor_q  <= core_divisor_d;
      op_q            <= op_d;
      neg_a_q         <= neg_a_d;
      neg_b_q         <= neg_b_d;
      word_q          <= word_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign core_start    = core_start_q;
  // Abort must reach the core in the same cycle as the flush.
  assign core_abort    = flush && ((state_q == START) || (state_q == CALC));
  assign core_dividend = core_dividend_q;
  assign core_divisor  = core_divisor_q;
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign resp_tag      = resp_tag_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a fixed-latency behavioural divider core.
module tb_div_sequencer;
  localparam int XLEN = 64;
  localparam int TAG_W = 5;
  localparam int LAT = 4;

  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_ready, flush = 1'b0;
  logic [1:0] req_op = 2'b00;
  logic req_word = 1'b0;
  logic [XLEN-1:0] req_rs1 = '0, req_rs2 = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic core_start, core_abort, core_done;
  logic [XLEN-1:0] core_dividend, core_divisor, core_quotient, core_remainder;
  logic resp_valid, resp_ready = 1'b1;
  logic [XLEN-1:0] resp_data;
  logic [TAG_W-1:0] resp_tag;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  div_sequencer #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
`ifdef DIV_WORD_OP_EN
    .req_word(req_word),
`endif
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag), .flush(flush),
    .core_start(core_start), .core_abort(core_abort), .core_dividend(core_dividend),
    .core_divisor(core_divisor), .core_done(core_done), .core_quotient(core_quotient),
    .core_remainder(core_remainder), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag)
  );

  // Core model ignores abort on purpose, so a stale done can arrive after a flush.
  logic [XLEN-1:0] m_dvd, m_dvs;
  int m_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt <= 0; core_done <= 1'b0; core_quotient <= '0; core_remainder <= '0;
      m_dvd <= '0; m_dvs <= '0;
    end else begin
      core_done <= 1'b0;
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          core_done      <= 1'b1;
          core_quotient  <= (m_dvs == 0) ? '1 : m_dvd / m_dvs;
          core_remainder <= (m_dvs == 0) ? m_dvd : m_dvd % m_dvs;
        end
      end
      if (core_start) begin
        m_dvd <= core_dividend; m_dvs <= core_divisor; m_cnt <= LAT;
      end
    end
  end

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [TAG_W-1:0] tag, output logic [XLEN-1:0] data,
                       output logic [TAG_W-1:0] rtag, output int lat, output int starts);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; starts = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (core_start) starts++;
      if (resp_valid) break;
    end
    data = resp_data; rtag = resp_tag;
  endtask

  typedef struct {
    logic [1:0]       op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  exp;
    logic             byp;
  } vec_t;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;
  localparam logic [XLEN-1:0] MINN = 64'h8000_0000_0000_0000;

  initial begin
    vec_t vecs[13];
    logic [XLEN-1:0] d;
    logic [TAG_W-1:0] t;
    int lat, starts;

    vecs[0]  = '{DIV,  64'd100,  64'd7,  5'd3,  64'd14, 1'b0};
    vecs[1]  = '{REM,  64'd100,  64'd7,  5'd4,  64'd2,  1'b0};
    vecs[2]  = '{DIV,  -64'd100, 64'd7,  5'd5,  64'hFFFF_FFFF_FFFF_FFF2, 1'b0};
    vecs[3]  = '{REM,  -64'd100, 64'd7,  5'd6,  64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[4]  = '{REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 5'd7, 64'd15, 1'b0};
    vecs[5]  = '{DIVU, 64'd5,    64'd0,  5'd8,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[6]  = '{REM,  64'd5,    64'd0,  5'd9,  64'd5,  1'b1};
    vecs[7]  = '{DIV,  MINN,     64'hFFFF_FFFF_FFFF_FFFF, 5'd10, MINN, 1'b1};
    vecs[8]  = '{REM,  MINN,     64'hFFFF_FFFF_FFFF_FFFF, 5'd11, 64'd0, 1'b1};
    vecs[9]  = '{DIV,  64'd100,  -64'd7, 5'd12, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0};
    vecs[10] = '{REM,  64'd100,  -64'd7, 5'd13, 64'd2,  1'b0};
    vecs[11] = '{DIVU, MINN,     64'hFFFF_FFFF_FFFF_FFFF, 5'd14, 64'd0, 1'b0};
    vecs[12] = '{REMU, 64'd7,    64'd0,  5'd31, 64'd7,  1'b1};

    repeat (3) @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_resp_tag", {59'd0, resp_tag}, 64'd0);
    chk("rst_core_start", {63'd0, core_start}, 64'd0);
    chk("rst_core_abort", {63'd0, core_abort}, 64'd0);
    chk("rst_core_dividend", core_dividend, 64'd0);
    chk("rst_core_divisor", core_divisor, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, d, t, lat, starts);
      chk($sformatf("v%0d_timeout", i), {63'd0, lat < 100}, 64'd1);
      chk($sformatf("v%0d_data", i), d, vecs[i].exp);
      chk($sformatf("v%0d_tag", i), {59'd0, t}, {59'd0, vecs[i].tag});
      chk($sformatf("v%0d_starts", i), starts, vecs[i].byp ? 64'd0 : 64'd1);
      if (vecs[i].byp) chk($sformatf("v%0d_byp_lat", i), lat, 64'd1);
    end

    // Backpressure: response held, new request ignored.
    @(negedge clk);
    resp_ready = 1'b0;
    do_op(DIV, 64'd100, 64'd7, 5'd9, d, t, lat, starts);
    chk("bp_first", d, 64'd14);
    req_valid = 1'b1; req_op = DIVU; req_rs1 = 64'd1; req_rs2 = 64'd1; req_tag = 5'd1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", c), {63'd0, resp_valid}, 64'd1);
      chk($sformatf("bp%0d_data", c), resp_data, 64'd14);
      chk($sformatf("bp%0d_tag", c), {59'd0, resp_tag}, 64'd9);
      chk($sformatf("bp%0d_ready", c), {63'd0, req_ready | core_start}, 64'd0);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_valid", {63'd0, resp_valid}, 64'd0);
    chk("bp_rel_ready", {63'd0, req_ready}, 64'd1);

    // Flush in IDLE blocks acceptance.
    req_valid = 1'b1; flush = 1'b1; req_op = DIVU; req_rs1 = 64'd8; req_rs2 = 64'd2;
    @(posedge clk);
    #1 req_valid = 1'b0; flush = 1'b0;
    chk("fidle_ready", {63'd0, req_ready}, 64'd1);
    chk("fidle_start", {63'd0, core_start}, 64'd0);

    // Flush three cycles into CALC; the stale core_done must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_op = DIV; req_rs1 = 64'd100; req_rs2 = 64'd7; req_tag = 5'd2;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    #1 chk("fl_abort", {63'd0, core_abort}, 64'd1);
    @(posedge clk);
    #1 flush = 1'b0;
    chk("fl_ready", {63'd0, req_ready}, 64'd1);
    chk("fl_abort_off", {63'd0, core_abort}, 64'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("fl%0d_no_resp", c), {63'd0, resp_valid | ~req_ready}, 64'd0);
    end
    do_op(DIVU, 64'd9, 64'd3, 5'd17, d, t, lat, starts);
    chk("fl_next_data", d, 64'd3);
    chk("fl_next_tag", {59'd0, t}, 64'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
